// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants and baud divisor helpers.
// Used by both the transmitter and the receiver so one parameter pair configures a link.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } uart_state_e;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int calc_half_bit(input int clock_freq, input int baud_rate);
    return calc_clks_per_bit(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a selectable reset level.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) with centre-of-bit sampling.
//   state  | meaning
//   IDLE   | line idle, waiting for rx_s low
//   START  | checking start bit at its centre
//   DATA   | sampling D0..D7 at bit centres
//   PARITY | sampling even-parity bit (UART_RX_PARITY_EN only)
//   STOP   | sampling stop bit, emitting result pulse
//   BREAK  | stop bit was low, waiting for the line to return high
module uart_receiver
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = calc_half_bit(CLOCK_FREQ, BAUD_RATE);

  localparam logic [31:0] HALF_LAST = 32'(HALF_BIT - 1);
  localparam logic [31:0] BIT_LAST  = 32'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  IDX_LAST  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q;
  logic [31:0]          cnt_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 busy_q;
  logic                 par_bad;
`ifdef UART_RX_PARITY_EN
  logic                 par_q;
  logic                 perr_q;
`endif

  uart_rx_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(rx),
    .sync_o (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_bad = (^shift_q) ^ par_q;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      cnt_q   <= cnt_q + 32'd1;
      case (state_q)
        S_IDLE: begin
          if (rx_s == START_LEVEL) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (rx_s == START_LEVEL) begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            par_q   <= rx_s;
            state_q <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s == STOP_LEVEL) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                perr_q <= 1'b1;
`endif
              end else begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end
            end else begin
              // Held-low line: park in BREAK so it cannot look like a new start bit.
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_s == STOP_LEVEL) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: behavioural serial transmitter plus an event-queue model.
module tb_uart_receiver;

  localparam int CLOCK_FREQ = 50_000_000;
  localparam int BAUD_RATE  = 3_125_000;
  localparam int CPB        = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF       = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ON  = 1'b1;
  localparam int FRAME_BITS = 11;
`else
  localparam bit PARITY_ON  = 1'b0;
  localparam int FRAME_BITS = 10;
`endif
  localparam int LATENCY = 2 + 1 + HALF + (FRAME_BITS - 1) * CPB;

  localparam int EV_VALID = 0;
  localparam int EV_FERR  = 1;
  localparam int EV_PERR  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  int         obs_kind[$];
  logic [7:0] obs_data[$];
  int         obs_cyc[$];
  logic       obs_busy[$];
  int         overlap = 0;

  int         exp_kind[$];
  logic [7:0] exp_data[$];
  logic [7:0] model_dout;

  uart_receiver #(
    .BAUD_RATE (BAUD_RATE),
    .CLOCK_FREQ(CLOCK_FREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (int'(data_valid) + int'(frame_err) + int'(parity_err) > 1) overlap++;
      if (data_valid || frame_err || parity_err) begin
        obs_kind.push_back(data_valid ? EV_VALID : (frame_err ? EV_FERR : EV_PERR));
        obs_data.push_back(data_out);
        obs_cyc.push_back(cycle);
        obs_busy.push_back(busy);
      end
    end
  end

  task automatic clear_queues();
    obs_kind.delete(); obs_data.delete(); obs_cyc.delete(); obs_busy.delete();
    exp_kind.delete(); exp_data.delete();
  endtask

  task automatic hold_bits(input int n);
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  // Drives one frame and records what a correct receiver must report for it.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    rx = 1'b0;
    hold_bits(1);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold_bits(1);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ bad_par;
    hold_bits(1);
`endif
    rx = stop;
    hold_bits(1);
    if (!stop) begin
      exp_kind.push_back(EV_FERR); exp_data.push_back(model_dout);
    end else if (PARITY_ON && bad_par) begin
      exp_kind.push_back(EV_PERR); exp_data.push_back(model_dout);
    end else begin
      model_dout = d;
      exp_kind.push_back(EV_VALID); exp_data.push_back(d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    model_dout = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h, expected 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b, expected 0", data_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b, expected 0", parity_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b valid %b, expected 0 0", busy, data_valid); end
  endtask

  task automatic test_loopback();
    int fall;
    int waited;
    clear_queues();
    fall = cycle;
    send_frame(8'hA5, 1'b0, 1'b1);
    waited = 0;
    while (obs_kind.size() == 0 && waited < LATENCY + 20) begin
      @(posedge clk); #1; waited++;
    end
    checks++;
    if (obs_kind.size() != 1) begin
      errors++; $display("FAIL loopback_pulse_count: got %0d, expected 1", obs_kind.size());
    end else begin
      checks++; if (obs_kind[0] != EV_VALID) begin errors++; $display("FAIL loopback_kind: got %0d, expected %0d", obs_kind[0], EV_VALID); end
      checks++; if (obs_data[0] !== 8'hA5) begin errors++; $display("FAIL loopback_data: got %h, expected a5", obs_data[0]); end
      checks++; if (obs_cyc[0] - fall < LATENCY - 2 || obs_cyc[0] - fall > LATENCY + 2) begin
        errors++; $display("FAIL loopback_latency: got %0d, expected %0d +/-2", obs_cyc[0] - fall, LATENCY);
      end
      checks++; if (obs_busy[0] !== 1'b0) begin errors++; $display("FAIL loopback_busy: got %b with pulse, expected 0", obs_busy[0]); end
    end
  endtask

  task automatic test_false_start();
    bit saw_busy;
    int waited;
    clear_queues();
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < HALF - 3; i++) begin
      @(posedge clk); #1;
      if (busy) saw_busy = 1'b1;
    end
    rx = 1'b1;
    waited = 0;
    while (busy && waited < HALF + 4) begin
      @(posedge clk); #1; waited++;
    end
    checks++; if (!saw_busy) begin errors++; $display("FAIL false_start_busy_rise: busy stayed 0, expected 1"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_start_busy_fall: busy %b after %0d cycles, expected 0", busy, waited); end
    hold_bits(2);
    checks++; if (obs_kind.size() != 0) begin errors++; $display("FAIL false_start_pulses: got %0d, expected 0", obs_kind.size()); end
  endtask

  task automatic test_frame_err();
    clear_queues();
    send_frame(8'h3C, 1'b0, 1'b0);
    hold_bits(3);
    rx = 1'b1;
    hold_bits(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_break_exit: busy %b, expected 0", busy); end
    send_frame(8'h81, 1'b0, 1'b1);
    repeat (4) @(posedge clk); #1;
    checks++; if (obs_kind.size() != exp_kind.size()) begin errors++; $display("FAIL ferr_count: got %0d, expected %0d", obs_kind.size(), exp_kind.size()); end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      checks++;
      if (obs_kind[i] != exp_kind[i] || obs_data[i] !== exp_data[i] || obs_busy[i] !== (exp_kind[i] == EV_FERR)) begin
        errors++; $display("FAIL ferr_event[%0d]: kind %0d data %h busy %b, expected kind %0d data %h", i, obs_kind[i], obs_data[i], obs_busy[i], exp_kind[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h55;
    clear_queues();
    for (int i = 0; i < 3; i++) send_frame(seq[i], 1'b0, 1'b1);
    repeat (4) @(posedge clk); #1;
    checks++; if (obs_kind.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d, expected 3", obs_kind.size()); end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      checks++;
      if (obs_kind[i] != exp_kind[i] || obs_data[i] !== exp_data[i] || obs_busy[i] !== 1'b0) begin
        errors++; $display("FAIL b2b_event[%0d]: kind %0d data %h busy %b, expected kind %0d data %h", i, obs_kind[i], obs_data[i], obs_busy[i], exp_kind[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'hC3;
    clear_queues();
    rx = 1'b0;
    hold_bits(1);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      hold_bits(1);
    end
    rx = d[3];
    repeat (HALF) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b, expected 1", busy); end
    rst = 1'b1;
    #2;
    model_dout = 8'h00;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midreset_data_out: got %h, expected 00", data_out); end
    checks++; if (busy !== 1'b0 || data_valid !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
      errors++; $display("FAIL midreset_flags: busy %b valid %b ferr %b perr %b, expected all 0", busy, data_valid, frame_err, parity_err);
    end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    hold_bits(1);
    send_frame(8'h7E, 1'b0, 1'b1);
    repeat (4) @(posedge clk); #1;
    checks++; if (obs_kind.size() != 1) begin errors++; $display("FAIL midreset_count: got %0d, expected 1", obs_kind.size()); end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      checks++;
      if (obs_kind[i] != exp_kind[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL midreset_event[%0d]: kind %0d data %h, expected kind %0d data %h", i, obs_kind[i], obs_data[i], exp_kind[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop;
    logic       bad_par;
    int         gap;
    clear_queues();
    for (int n = 0; n < 24; n++) begin
      d       = 8'($urandom);
      stop    = ($urandom_range(0, 4) != 0);
      bad_par = ($urandom_range(0, 3) == 0);
      send_frame(d, bad_par, stop);
      if (!stop) begin
        gap = $urandom_range(0, 2 * CPB);
        if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
        rx = 1'b1;
        repeat (HALF + $urandom_range(0, CPB)) @(posedge clk);
        #1;
      end else begin
        gap = $urandom_range(0, CPB);
        if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
      end
    end
    rx = 1'b1;
    hold_bits(1);
    checks++; if (obs_kind.size() != exp_kind.size()) begin errors++; $display("FAIL rand_count: got %0d, expected %0d", obs_kind.size(), exp_kind.size()); end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      checks++;
      if (obs_kind[i] != exp_kind[i] || obs_data[i] !== exp_data[i] || obs_busy[i] !== (exp_kind[i] == EV_FERR)) begin
        errors++; $display("FAIL rand_event[%0d]: kind %0d data %h busy %b, expected kind %0d data %h", i, obs_kind[i], obs_data[i], obs_busy[i], exp_kind[i], exp_data[i]);
      end
    end
    checks++; if (overlap != 0) begin errors++; $display("FAIL pulse_exclusive: %0d overlapping cycles, expected 0", overlap); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_queues();
    send_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1);
    repeat (4) @(posedge clk); #1;
    checks++; if (obs_kind.size() != 3) begin errors++; $display("FAIL parity_count: got %0d, expected 3", obs_kind.size()); end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      checks++;
      if (obs_kind[i] != exp_kind[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL parity_event[%0d]: kind %0d data %h, expected kind %0d data %h", i, obs_kind[i], obs_data[i], exp_kind[i], exp_data[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_loopback();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receives 8N1 serial frames on a single input line and presents each received byte as a parallel word with a one-cycle valid strobe. It is the receive-side partner of the team's UART transmitter and sits directly downstream of a transmitter's `tx` line, whether across the board or in loopback. It uses the same 50 MHz system clock and the same baud parameterisation as the transmitter, so one pair of parameter values configures both ends of a link.

## Interface
- `BAUD_RATE`, default 9600: serial bit rate in bits per second.
- `CLOCK_FREQ`, default 50000000: system clock frequency in Hz.
- `CLKS_PER_BIT`, localparam, value `CLOCK_FREQ / BAUD_RATE` with integer division: 5208 at the defaults.
- `HALF_BIT`, localparam, value `CLKS_PER_BIT / 2`: 2604 at the defaults.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `data_out`  out  8  last received byte, LSB received first; holds its value between frames.
- `data_valid`  out  1  one-cycle pulse; `data_out` is valid in that cycle.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `parity_err`  out  1  one-cycle pulse on a parity mismatch; tied to 0 when parity is compiled out.
- `busy`  out  1  high while a frame is in progress (any state other than IDLE).

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All logic below uses the synchronized signal `rx_s`.
- Bit counter: 32 bits wide. It clears on every state entry and increments each cycle.
- State machine:
  - IDLE: when `rx_s`=0, go to START.
  - START: when the counter reaches `HALF_BIT-1`, sample `rx_s`.
    - If 0, go to DATA with bit index 0.
    - If 1, this is a false start: go to IDLE with no output pulses.
  - DATA: when the counter reaches `CLKS_PER_BIT-1`, sample `rx_s` into shift register bit [index].
    - After index 7, go to PARITY if compiled in, otherwise go to STOP.
  - PARITY (compiled in only): sample at `CLKS_PER_BIT-1`, then go to STOP.
  - STOP: sample at `CLKS_PER_BIT-1`.
    - `rx_s`=1: load `data_out`, pulse `data_valid`, or pulse `parity_err` instead if parity mismatched. Go to IDLE.
    - `rx_s`=0: pulse `frame_err`. `data_out` is not updated. Go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This stops a held-low line (break condition) from retriggering START.
- `data_valid`, `frame_err` and `parity_err` are mutually exclusive. Each is high for exactly one cycle per frame.
- Reset mid-frame aborts the frame immediately. No pulse is emitted. The next frame starting after reset is received normally.

## Timing
- Reset values: `data_out`=0x00, `data_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, state=IDLE.
- Synchronizer delay: 2 cycles from `rx` to `rx_s`.
- START is entered 1 cycle after `rx_s` falls. `busy` rises in that same cycle.
- Every sample point is the centre of its bit, within ±1 clock.
- Frame latency (8N1): the result pulse occurs `2 + 1 + HALF_BIT + 9*CLKS_PER_BIT` cycles after `rx` falls, ±1 cycle. At the defaults that is 49479 cycles.
- Outputs update one cycle after the stop-bit sample. `busy` falls in the same cycle as the result pulse.
- Back-to-back frames: a start bit that immediately follows a stop bit is detected, because IDLE is re-entered half a bit before the stop bit ends.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame is 8E1. The parity bit follows D7.
  - Even parity: the XOR of D0..D7 and the parity bit must equal 0.
  - On mismatch with a valid stop bit, `parity_err` pulses, `data_valid` stays 0 and `data_out` is not updated.
  - Latency grows by `CLKS_PER_BIT`.
- `UART_RX_PARITY_EN` undefined:
  - The frame is 8N1, the PARITY state is absent and `parity_err` is constant 0.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP, BREAK; 3 bits);
  - the `CLKS_PER_BIT` and `HALF_BIT` derivation, as a function of `CLOCK_FREQ` and `BAUD_RATE`;
  - the frame constants: 8 data bits, start level 0, stop level 1.
- The transmitter and receiver share this package.
- One sub-module: `uart_rx_sync`, a 2-flop synchronizer with a reset value parameter, instantiated here with reset value 1.

## Test plan
- Loopback through a transmitter instance (defaults), sending 0xA5:
  - `data_valid` pulses once, within 49479±2 cycles of the `tx` falling edge, with `data_out`=0xA5.
  - `frame_err` stays 0 and `busy` falls with the pulse.
- False start: drive `rx` low for 1000 cycles, then high. No output pulse occurs, and `busy` returns to 0 within `HALF_BIT`+4 cycles.
- Framing error: send 0x3C with the stop bit low, then hold `rx` low for 3 bit times, then release it.
  - `frame_err` pulses once, `data_out` is unchanged and no second frame is detected.
  - A following frame 0x81 is received correctly.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle time between them: three `data_valid` pulses, in order, with the correct data.
- Reset mid-frame: assert `rst` during D3 of the first frame.
  - All outputs return to their reset values immediately and no pulse is emitted.
  - Frame 0x7E sent after reset is received correctly.
- With `UART_RX_PARITY_EN`:
  - 0xA5 with parity 0 gives `data_valid`.
  - 0xA5 with parity 1 gives a `parity_err` pulse and no `data_valid`.
